// File: rtl/ether_pkg.sv
// Shared Ethernet receive-path types and default constants.
package ether_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StPre,
    StData,
    StDrop
  } rx_state_e;

  localparam logic [1:0]  PRE_DIBIT  = 2'b01;
  localparam logic [1:0]  SFD_DIBIT  = 2'b11;
  localparam int unsigned MIN_PRE    = 28;
  localparam int unsigned MAX_DIBITS = 6144;

endpackage

// File: rtl/rmii_rx.sv
// RMII receive framer: strips preamble/SFD and streams payload dibits in wire order.
// Frames with short preamble, bad SFD or length overrun are discarded until carrier drops.
module rmii_rx #(
  parameter int unsigned MIN_PRE    = ether_pkg::MIN_PRE,
  parameter int unsigned MAX_DIBITS = ether_pkg::MAX_DIBITS
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       crsdv,
  input  logic [1:0] rxd,
  output logic       axiov,
  output logic [1:0] axiod,
  output logic       sof,
  output logic       eof,
  output logic       err
);

  localparam int unsigned PW = $clog2(MIN_PRE + 1);
  localparam int unsigned DW = $clog2(MAX_DIBITS + 1);

  ether_pkg::rx_state_e state_q, state_d;
  logic [PW-1:0] pre_cnt_q, pre_cnt_d;
  logic [DW-1:0] dib_cnt_q, dib_cnt_d;
  logic          axiov_q, axiov_d;
  logic [1:0]    axiod_q, axiod_d;
  logic          sof_q, sof_d;
  logic          eof_q, eof_d;
  logic          err_q, err_d;

  always_comb begin
    state_d   = state_q;
    pre_cnt_d = pre_cnt_q;
    dib_cnt_d = dib_cnt_q;
    axiov_d   = 1'b0;
    axiod_d   = axiod_q;
    sof_d     = 1'b0;
    eof_d     = 1'b0;
    err_d     = 1'b0;

    case (state_q)
      ether_pkg::StIdle: begin
        pre_cnt_d = '0;
        dib_cnt_d = '0;
        if (crsdv) begin
          if (rxd == ether_pkg::PRE_DIBIT) begin
            state_d   = ether_pkg::StPre;
            pre_cnt_d = PW'(1);
          end else begin
            state_d = ether_pkg::StDrop;
          end
        end
      end

      ether_pkg::StPre: begin
        if (!crsdv) begin
          state_d   = ether_pkg::StIdle;
          pre_cnt_d = '0;
        end else if (rxd == ether_pkg::PRE_DIBIT) begin
          if (pre_cnt_q < PW'(MIN_PRE)) pre_cnt_d = pre_cnt_q + PW'(1);
        end else if (rxd == ether_pkg::SFD_DIBIT && pre_cnt_q >= PW'(MIN_PRE)) begin
          state_d   = ether_pkg::StData;
          pre_cnt_d = '0;
          dib_cnt_d = '0;
        end else begin
          state_d   = ether_pkg::StDrop;
          pre_cnt_d = '0;
        end
      end

      ether_pkg::StData: begin
        if (!crsdv) begin
          state_d   = ether_pkg::StIdle;
          eof_d     = (dib_cnt_q != '0);
          dib_cnt_d = '0;
        end else if (dib_cnt_q == DW'(MAX_DIBITS)) begin
          // Overrun dibit is swallowed; the frame is abandoned without eof.
          state_d   = ether_pkg::StDrop;
          err_d     = 1'b1;
          dib_cnt_d = '0;
        end else begin
          axiov_d   = 1'b1;
          axiod_d   = rxd;
          sof_d     = (dib_cnt_q == '0);
          dib_cnt_d = dib_cnt_q + DW'(1);
        end
      end

      ether_pkg::StDrop: begin
        pre_cnt_d = '0;
        dib_cnt_d = '0;
        if (!crsdv) state_d = ether_pkg::StIdle;
      end

      default: state_d = ether_pkg::StDrop;
    endcase
  end

  // Reset lands in drop so a frame already on the wire is ignored until carrier drops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ether_pkg::StDrop;
      pre_cnt_q <= '0;
      dib_cnt_q <= '0;
      axiov_q   <= 1'b0;
      axiod_q   <= 2'b00;
      sof_q     <= 1'b0;
      eof_q     <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      pre_cnt_q <= pre_cnt_d;
      dib_cnt_q <= dib_cnt_d;
      axiov_q   <= axiov_d;
      axiod_q   <= axiod_d;
      sof_q     <= sof_d;
      eof_q     <= eof_d;
      err_q     <= err_d;
    end
  end

  assign axiov = axiov_q;
  assign axiod = axiod_q;
  assign sof   = sof_q;
  assign eof   = eof_q;
  assign err   = err_q;

endmodule

// File: tb/tb_rmii_rx.sv
// Directed bench for rmii_rx: frame acceptance, preamble/SFD rejection, overrun and reset.
module tb_rmii_rx;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       crsdv = 1'b0;
  logic [1:0] rxd = 2'b00;
  logic       axiov;
  logic [1:0] axiod;
  logic       sof;
  logic       eof;
  logic       err;

  always #10 clk = ~clk;

  rmii_rx dut (
    .clk   (clk),
    .rst   (rst),
    .crsdv (crsdv),
    .rxd   (rxd),
    .axiov (axiov),
    .axiod (axiod),
    .sof   (sof),
    .eof   (eof),
    .err   (err)
  );

  int errors = 0;
  int checks = 0;

  // Output monitor, sampled on the falling edge.
  int n_v = 0, n_sof = 0, n_eof = 0, n_err = 0, n_bad = 0;
  logic prev_v = 1'b0;
  logic [1:0] dq[$];

  always @(negedge clk) begin
    if (axiov) begin
      n_v++;
      dq.push_back(axiod);
    end
    if (sof) n_sof++;
    if (eof) n_eof++;
    if (err) n_err++;
    if (axiov && !prev_v && !sof) n_bad++;
    if (sof && !(axiov && !prev_v)) n_bad++;
    if (eof && (axiov || !prev_v)) n_bad++;
    if (err && (axiov || eof || !prev_v)) n_bad++;
    if (sof && eof) n_bad++;
    prev_v = axiov;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic send(input logic cv, input logic [1:0] d);
    @(negedge clk);
    #1;
    crsdv = cv;
    rxd   = d;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) send(1'b0, 2'b00);
  endtask

  task automatic preamble(input int n);
    for (int i = 0; i < n; i++) send(1'b1, 2'b01);
    send(1'b1, 2'b11);
  endtask

  logic [1:0] exp36[16] = '{2'd1, 2'd1, 2'd1, 2'd1, 2'd3, 2'd0, 2'd2, 2'd2,
                            2'd1, 2'd1, 2'd3, 2'd2, 2'd0, 2'd1, 2'd1, 2'd2};
  logic [1:0] fa[8] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd3, 2'd2, 2'd1, 2'd0};
  logic [1:0] fb[8] = '{2'd2, 2'd2, 2'd1, 2'd1, 2'd3, 2'd0, 2'd0, 2'd3};

  int bv, bs, be, br, bq;
  logic [1:0] last_d;

  initial begin
    #1 rst = 1'b1;
    #5;
    chk("rst_axiov", 32'(axiov), 0);
    chk("rst_axiod", 32'(axiod), 0);
    chk("rst_sof",   32'(sof),   0);
    chk("rst_eof",   32'(eof),   0);
    chk("rst_err",   32'(err),   0);

    // Carrier with preamble already active at reset release must be ignored.
    crsdv = 1'b1;
    rxd   = 2'b01;
    bv = n_v; bs = n_sof;
    @(negedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 40; i++) send(1'b1, 2'b01);
    idle(3);
    chk("inflight_axiov", 32'(n_v - bv), 0);
    chk("inflight_sof",   32'(n_sof - bs), 0);

    // Nominal frame: 31 preamble dibits, SFD, 16 payload dibits.
    bv = n_v; bs = n_sof; be = n_eof; br = n_err; bq = dq.size();
    preamble(31);
    for (int i = 0; i < 16; i++) send(1'b1, exp36[i]);
    idle(3);
    chk("f16_axiov", 32'(n_v - bv), 16);
    chk("f16_sof",   32'(n_sof - bs), 1);
    chk("f16_eof",   32'(n_eof - be), 1);
    chk("f16_err",   32'(n_err - br), 0);
    for (int i = 0; i < 16; i++) chk($sformatf("f16_d%0d", i), 32'(dq[bq + i]), 32'(exp36[i]));

    // Short preamble (20) is dropped, including the payload that follows.
    bv = n_v; bs = n_sof; be = n_eof;
    preamble(20);
    for (int i = 0; i < 6; i++) send(1'b1, 2'(i));
    idle(2);
    chk("short20_axiov", 32'(n_v - bv), 0);
    chk("short20_sof",   32'(n_sof - bs), 0);
    chk("short20_eof",   32'(n_eof - be), 0);

    // One short of the minimum (27) is still dropped.
    bv = n_v;
    preamble(27);
    for (int i = 0; i < 4; i++) send(1'b1, 2'b10);
    idle(2);
    chk("short27_axiov", 32'(n_v - bv), 0);

    // Exactly 28 preamble dibits and one dibit past the length limit.
    bv = n_v; bs = n_sof; be = n_eof; br = n_err;
    preamble(28);
    for (int i = 0; i < 6145; i++) send(1'b1, 2'(i));
    idle(3);
    chk("ovr_axiov", 32'(n_v - bv), 6144);
    chk("ovr_sof",   32'(n_sof - bs), 1);
    chk("ovr_err",   32'(n_err - br), 1);
    chk("ovr_eof",   32'(n_eof - be), 0);
    last_d = dq[dq.size() - 1];
    chk("ovr_last_d", 32'(last_d), 3);

    // Reset mid-frame; the 10th axiov is cut short before the monitor samples it.
    bv = n_v; bs = n_sof; be = n_eof; br = n_err; bq = dq.size();
    preamble(30);
    for (int i = 0; i < 10; i++) send(1'b1, 2'b10);
    @(posedge clk);
    #2;
    chk("rstmid_pre_axiov", 32'(axiov), 1);
    rst = 1'b1;
    #1;
    chk("rstmid_axiov", 32'(axiov), 0);
    chk("rstmid_axiod", 32'(axiod), 0);
    chk("rstmid_sof",   32'(sof),   0);
    for (int i = 0; i < 3; i++) send(1'b1, 2'b10);
    rst = 1'b0;
    for (int i = 0; i < 30; i++) send(1'b1, 2'b01);
    send(1'b1, 2'b11);
    for (int i = 0; i < 4; i++) send(1'b1, 2'b00);
    idle(1);
    preamble(30);
    for (int i = 0; i < 8; i++) send(1'b1, fa[i]);
    idle(3);
    chk("rstmid_axiov_total", 32'(n_v - bv), 17);
    chk("rstmid_sof_total",   32'(n_sof - bs), 2);
    chk("rstmid_eof_total",   32'(n_eof - be), 1);
    chk("rstmid_err_total",   32'(n_err - br), 0);
    for (int i = 0; i < 8; i++) chk($sformatf("rstmid_d%0d", i), 32'(dq[bq + 9 + i]), 32'(fa[i]));

    // Back-to-back frames with a single idle cycle between them.
    bv = n_v; bs = n_sof; be = n_eof; bq = dq.size();
    preamble(28);
    for (int i = 0; i < 8; i++) send(1'b1, fa[i]);
    idle(1);
    preamble(28);
    for (int i = 0; i < 8; i++) send(1'b1, fb[i]);
    idle(3);
    chk("b2b_axiov", 32'(n_v - bv), 16);
    chk("b2b_sof",   32'(n_sof - bs), 2);
    chk("b2b_eof",   32'(n_eof - be), 2);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("b2b_a%0d", i), 32'(dq[bq + i]), 32'(fa[i]));
      chk($sformatf("b2b_b%0d", i), 32'(dq[bq + 8 + i]), 32'(fb[i]));
    end

    chk("pulse_rules", 32'(n_bad), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rmii_rx.md
RMII_RX -- requirements
Module: rmii_rx

Interface
REQ-001 Parameter MIN_PRE, default 28: minimum count of consecutive 2'b01 preamble dibits that must precede the SFD dibit.
REQ-002 Parameter MAX_DIBITS, default 6144: maximum payload dibits per frame (1536 bytes).
REQ-003 clk  input  1  single system clock (50 MHz RMII reference clock); all logic on its rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 crsdv  input  1  RMII carrier-sense/data-valid.
REQ-006 rxd  input  2  RMII receive dibit; rxd[0] is the earlier bit on the wire.
REQ-007 axiov  output  1  payload dibit valid.
REQ-008 axiod  output  2  payload dibit (destination MAC through FCS), wire order, feeds the downstream bitorder and checksum stages.
REQ-009 sof  output  1  one-cycle pulse, coincident with the first axiov of a frame.
REQ-010 eof  output  1  one-cycle pulse in the cycle after the last axiov of an accepted frame.
REQ-011 err  output  1  one-cycle pulse when a frame is aborted for length overrun.

Function
REQ-012 The block SHALL implement states IDLE, PRE, DATA and DROP.
REQ-013 IDLE: crsdv=1 and rxd=01 -> PRE with pre_cnt=1; crsdv=1 and any other rxd -> DROP; crsdv=0 -> stay in IDLE.
REQ-014 PRE: crsdv=0 -> IDLE, with no output activity.
REQ-015 PRE: rxd=01 -> pre_cnt increments, saturating at MIN_PRE.
REQ-016 PRE: rxd=11 with pre_cnt>=MIN_PRE -> DATA (SFD accepted).
REQ-017 PRE: rxd=11 with pre_cnt<MIN_PRE, or rxd=00 or rxd=10 -> DROP.
REQ-018 DATA, crsdv=1: each sampled dibit SHALL be emitted on axiod with axiov=1, one cycle after the sampling edge.
REQ-019 DATA, crsdv=1: dibit counter increments once per emitted dibit.
REQ-020 DATA, crsdv=0: -> IDLE; eof=1 and axiov=0 in that cycle; eof only if at least one dibit was emitted.
REQ-021 DATA: the dibit that would make the count exceed MAX_DIBITS SHALL not be emitted; instead err=1, no eof, -> DROP.
REQ-022 DROP: axiov=0; exit to IDLE only when crsdv=0 is sampled.
REQ-023 sof SHALL assert on the first axiov after an SFD and at no other time.
REQ-024 All outputs SHALL be registered.
REQ-025 axiod SHALL hold its last value while axiov=0.
REQ-026 The dibit counter width SHALL be clog2(MAX_DIBITS+1) bits; pre_cnt width SHALL be clog2(MIN_PRE+1) bits.
REQ-027 sof and eof SHALL never assert in the same cycle.
REQ-028 err and eof SHALL never assert in the same cycle.
REQ-029 Back-to-back frames: a single crsdv=0 cycle between frames SHALL suffice (DATA -> IDLE -> PRE).

Reset
REQ-030 While rst=1, outputs SHALL be axiov=0, axiod=00, sof=0, eof=0, err=0, and all counters SHALL be 0.
REQ-031 The state on reset SHALL be DROP, so a frame already in progress at reset release is discarded until crsdv=0.
REQ-032 rst asserted mid-frame SHALL clear all outputs asynchronously; no eof or err is generated for the interrupted frame.

Structure
REQ-033 The state enum and default constants (PRE_DIBIT=2'b01, SFD_DIBIT=2'b11, MIN_PRE, MAX_DIBITS) SHALL live in shared package ether_pkg.
REQ-034 The block SHALL be a single module with no sub-modules; its output connects directly to the existing checksum/bitorder inputs.

Verification
REQ-035 Reset release with crsdv=1, rxd=01, held for 40 cycles, then crsdv=0 -> no axiov, no sof at any point.
REQ-036 Frame of 31x01 + 11, then 16 dibits 01,01,01,01,11,00,10,10,01,01,11,10,00,01,01,10, then crsdv=0 -> axiov high for exactly 16 cycles with axiod in that order, sof on the first, eof one cycle after the last.
REQ-037 Preamble of 20x01 + 11 -> DROP; no axiov, sof or eof until the next valid frame.
REQ-038 Valid preamble, SFD, then 6145 payload dibits -> exactly 6144 axiov, err pulse on dibit 6145, no eof.
REQ-039 rst pulse after 10 payload dibits, crsdv held high -> outputs 0 immediately; remainder of the frame ignored; the next frame after a crsdv=0 gap decodes normally.
REQ-040 Two valid 8-dibit frames separated by one crsdv=0 cycle -> two sof and two eof pulses, 16 axiov total.
